// File: rtl/edge_sync_pkg.sv
// Shared types and constants for the multi-channel edge synchroniser.
// Optional glitch filter is enabled by defining EDGE_SYNC_FILTER_EN.
package edge_sync_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   localparam int unsigned CNT_W             = 8;
   localparam int unsigned CNT_MAX           = 255;
   localparam int unsigned FILT_W            = 8;
   localparam int unsigned DEF_CHANNELS      = 4;
   localparam int unsigned DEF_SYNC_STAGES   = 2;
   localparam int unsigned DEF_FILTER_CYCLES = 4;

   // True when the cur/prev level pair is an edge selected by mode.
   function automatic logic edge_hit(input edge_mode_e mode, input logic cur, input logic prev);
      logic hit;
      hit = 1'b0;
      case (mode)
         EDGE_RISE: hit = cur & ~prev;
         EDGE_FALL: hit = ~cur & prev;
         EDGE_BOTH: hit = cur ^ prev;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// One channel: synchroniser chain, optional glitch filter, edge detector.
// The glitch filter is present only when EDGE_SYNC_FILTER_EN is defined.
module edge_sync_chan
   import edge_sync_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
`ifdef EDGE_SYNC_FILTER_EN
   ,
   parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       slow,
   input  logic [1:0] mode,
   input  logic       armed,
   output logic       level,
   output logic       pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync_s;
   logic                   level_s;
   logic                   prev_q;
   logic                   prev_d;
   logic                   pulse_q;
   logic                   pulse_d;

   // Shift the asynchronous level into the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], slow};
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_SYNC_FILTER_EN
   logic [FILT_W-1:0] fcnt_q;
   logic [FILT_W-1:0] fcnt_d;
   logic              level_q;
   logic              level_d;

   // Accept a new level only after it has persisted for FILTER_CYCLES edges.
   always_comb begin
      fcnt_d  = '0;
      level_d = level_q;
      if (sync_s != level_q) begin
         if (fcnt_q == FILT_W'(FILTER_CYCLES - 1)) begin
            level_d = sync_s;
            fcnt_d  = '0;
         end else begin
            fcnt_d = fcnt_q + FILT_W'(1);
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fcnt_q  <= '0;
         level_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         level_q <= level_d;
      end
   end

   assign level_s = level_q;
`else
   assign level_s = sync_s;
`endif

   // Edge detection against the previous level; suppressed until warmed up.
   always_comb begin
      prev_d  = level_s;
      pulse_d = armed & edge_hit(edge_mode_e'(mode), level_s, prev_q);
   end

   // Synchroniser, history and strobe registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign level = level_s;
   assign pulse = pulse_q;

endmodule

// File: rtl/edge_sync_multi.sv
// Multi-channel asynchronous level synchroniser with per-channel edge strobes,
// post-reset warm-up and a saturating event counter.
// Define EDGE_SYNC_FILTER_EN to add a per-channel glitch filter.
module edge_sync_multi
   import edge_sync_pkg::*;
#(
   parameter int unsigned CHANNELS      = DEF_CHANNELS,
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
   input  logic                  FAST,
   input  logic                  RST_N,
   input  logic [CHANNELS-1:0]   SLOW,
   input  logic [2*CHANNELS-1:0] MODE,
   input  logic                  CLR,
   output logic [CHANNELS-1:0]   LEVEL,
   output logic [CHANNELS-1:0]   PULSE,
   output logic                  ARMED,
   output logic [CNT_W-1:0]      EVENT_CNT
);

`ifdef EDGE_SYNC_FILTER_EN
   localparam bit FILT_ON = 1'b1;
`else
   localparam bit FILT_ON = 1'b0;
`endif

   // Warm-up covers the time for a level held across reset to reach the detector.
   localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1 + (FILT_ON ? FILTER_CYCLES : 0);
   localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);
   localparam int unsigned SUM_W      = CNT_W + 1;

   logic [ARM_W-1:0]    arm_cnt_q;
   logic [ARM_W-1:0]    arm_cnt_d;
   logic                armed_q;
   logic                armed_d;
   logic [CNT_W-1:0]    event_cnt_q;
   logic [CNT_W-1:0]    event_cnt_d;
   logic [SUM_W-1:0]    sum;
   logic [CHANNELS-1:0] pulse_w;

   // Per-channel synchroniser and edge detector.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      edge_sync_chan #(
         .SYNC_STAGES   (SYNC_STAGES)
`ifdef EDGE_SYNC_FILTER_EN
         ,
         .FILTER_CYCLES (FILTER_CYCLES)
`endif
      ) u_chan (
         .clk   (FAST),
         .rst_n (RST_N),
         .slow  (SLOW[g]),
         .mode  (MODE[2*g +: 2]),
         .armed (armed_q),
         .level (LEVEL[g]),
         .pulse (pulse_w[g])
      );
   end

   // Count edges after reset release, then hold ARMED until the next reset.
   always_comb begin
      arm_cnt_d = arm_cnt_q;
      armed_d   = armed_q;
      if (!armed_q) begin
         if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
            armed_d = 1'b1;
         end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
         end
      end
   end

   // Accumulate strobes with saturation; CLR overrides same-cycle strobes.
   always_comb begin
      sum = SUM_W'(event_cnt_q);
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         sum = sum + SUM_W'(pulse_w[i]);
      end
      event_cnt_d = event_cnt_q;
      if (CLR) begin
         event_cnt_d = '0;
      end else if (armed_q) begin
         event_cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_W'(CNT_MAX) : sum[CNT_W-1:0];
      end
   end

   // Warm-up and event counter registers.
   always_ff @(posedge FAST) begin
      if (!RST_N) begin
         arm_cnt_q   <= '0;
         armed_q     <= 1'b0;
         event_cnt_q <= '0;
      end else begin
         arm_cnt_q   <= arm_cnt_d;
         armed_q     <= armed_d;
         event_cnt_q <= event_cnt_d;
      end
   end

   assign PULSE     = pulse_w;
   assign ARMED     = armed_q;
   assign EVENT_CNT = event_cnt_q;

endmodule

// File: tb/tb_edge_sync_multi.sv
// Self-checking bench for edge_sync_multi in its default configuration.
module tb_edge_sync_multi;

   logic       FAST = 1'b0;
   logic       RST_N;
   logic [3:0] SLOW;
   logic [7:0] MODE;
   logic       CLR;
   logic [3:0] LEVEL;
   logic [3:0] PULSE;
   logic       ARMED;
   logic [7:0] EVENT_CNT;

   localparam logic [7:0] M_RISE = 8'h55;
   localparam logic [7:0] M_MIX  = 8'h39;
   localparam logic [7:0] M_MIX2 = 8'h3B;

   int n_chk  = 0;
   int n_pass = 0;

   edge_sync_multi dut (
      .FAST      (FAST),
      .RST_N     (RST_N),
      .SLOW      (SLOW),
      .MODE      (MODE),
      .CLR       (CLR),
      .LEVEL     (LEVEL),
      .PULSE     (PULSE),
      .ARMED     (ARMED),
      .EVENT_CNT (EVENT_CNT)
   );

   always #5 FAST = ~FAST;

   typedef struct {
      logic       rst_n;
      logic [3:0] slow;
      logic [7:0] mode;
      logic       clr;
      logic [3:0] level;
      logic [3:0] pulse;
      logic       armed;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   // Scoreboard: slow values seen at the last four edges, newest last.
   logic [3:0]  hist[$];
   int unsigned m_edges;
   logic [3:0]  m_pulse;
   logic [7:0]  m_cnt;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic v(input logic r, input logic [3:0] s, input logic [7:0] m, input logic c,
                    input logic [3:0] l, input logic [3:0] p, input logic a, input logic [7:0] n);
      tbl.push_back('{r, s, m, c, l, p, a, n});
   endtask

   // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
   task automatic tick(input logic r, input logic [3:0] s, input logic [7:0] m, input logic c);
      RST_N = r;
      SLOW  = s;
      MODE  = m;
      CLR   = c;
      @(posedge FAST);
      @(negedge FAST);
   endtask

   function automatic logic [3:0] match(input logic [7:0] m, input logic [3:0] cur, input logic [3:0] prv);
      logic [3:0] r;
      logic [1:0] md;
      r = 4'h0;
      for (int i = 0; i < 4; i++) begin
         md = m[2*i +: 2];
         r[i] = (cur[i] != prv[i]) &&
                ((md == 2'b11) || (md == 2'b01 && cur[i]) || (md == 2'b10 && !cur[i]));
      end
      return r;
   endfunction

   // Advance the reference by one edge with the inputs that were applied to it.
   task automatic model_step(input logic r, input logic [3:0] s, input logic [7:0] m, input logic c);
      int unsigned sum;
      if (!r) begin
         hist    = '{4'h0, 4'h0, 4'h0, 4'h0};
         m_edges = 0;
         m_pulse = 4'h0;
         m_cnt   = 8'h00;
      end else begin
         m_edges++;
         sum   = int'(m_cnt) + $countones(m_pulse);
         m_cnt = c ? 8'h00 : ((sum > 255) ? 8'hFF : 8'(sum));
         hist.push_back(s);
         hist.delete(0);
         m_pulse = (m_edges >= 4) ? match(m, hist[1], hist[0]) : 4'h0;
      end
   endtask

   task automatic mtick(input logic r, input logic [3:0] s, input logic [7:0] m, input logic c);
      tick(r, s, m, c);
      model_step(r, s, m, c);
      chk("m.lvl", 8'(LEVEL), 8'(hist[2]));
      chk("m.pls", 8'(PULSE), 8'(m_pulse));
      chk("m.arm", 8'(ARMED), 8'(m_edges >= 3));
      chk("m.cnt", EVENT_CNT, m_cnt);
   endtask

   initial begin
      logic [3:0] rs;
      logic [7:0] rm;

      RST_N = 1'b0;
      SLOW  = 4'h0;
      MODE  = M_RISE;
      CLR   = 1'b0;

      // rst  slow  mode    clr  level pulse armed cnt
      // Reset, warm-up and a single rising edge on channel 0.
      v(0, 4'h0, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(0, 4'h0, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(1, 4'h0, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(1, 4'h0, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(1, 4'h0, M_RISE, 0, 4'h0, 4'h0, 1, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h0, 4'h0, 1, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h1, 4'h0, 1, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h1, 4'h1, 1, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h1, 4'h0, 1, 8'd1);
      // Mixed modes: rise, then simultaneous falls on channels 1..3.
      v(1, 4'hF, M_MIX,  0, 4'h1, 4'h0, 1, 8'd1);
      v(1, 4'hF, M_MIX,  0, 4'hF, 4'h0, 1, 8'd1);
      v(1, 4'hF, M_MIX,  0, 4'hF, 4'h4, 1, 8'd1);
      v(1, 4'hF, M_MIX,  0, 4'hF, 4'h0, 1, 8'd2);
      v(1, 4'h1, M_MIX,  0, 4'hF, 4'h0, 1, 8'd2);
      v(1, 4'h1, M_MIX,  0, 4'h1, 4'h0, 1, 8'd2);
      v(1, 4'h1, M_MIX,  0, 4'h1, 4'h6, 1, 8'd2);
      v(1, 4'h1, M_MIX,  0, 4'h1, 4'h0, 1, 8'd4);
      // Channel 3 in OFF mode toggles without strobing.
      v(1, 4'h9, M_MIX,  0, 4'h1, 4'h0, 1, 8'd4);
      v(1, 4'h9, M_MIX,  0, 4'h9, 4'h0, 1, 8'd4);
      v(1, 4'h1, M_MIX,  0, 4'h9, 4'h0, 1, 8'd4);
      v(1, 4'h1, M_MIX,  0, 4'h1, 4'h0, 1, 8'd4);
      v(1, 4'h1, M_MIX,  0, 4'h1, 4'h0, 1, 8'd4);
      // Mode change alone is silent; the next edge uses the new mode.
      v(1, 4'h1, M_MIX2, 0, 4'h1, 4'h0, 1, 8'd4);
      v(1, 4'h0, M_MIX2, 0, 4'h1, 4'h0, 1, 8'd4);
      v(1, 4'h0, M_MIX2, 0, 4'h0, 4'h0, 1, 8'd4);
      v(1, 4'h0, M_MIX2, 0, 4'h0, 4'h1, 1, 8'd4);
      v(1, 4'h0, M_MIX2, 0, 4'h0, 4'h0, 1, 8'd5);
      // Levels held high through reset produce no strobe.
      v(0, 4'hF, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(0, 4'hF, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(1, 4'hF, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(1, 4'hF, M_RISE, 0, 4'hF, 4'h0, 0, 8'd0);
      v(1, 4'hF, M_RISE, 0, 4'hF, 4'h0, 1, 8'd0);
      v(1, 4'hF, M_RISE, 0, 4'hF, 4'h0, 1, 8'd0);
      v(1, 4'hF, M_RISE, 0, 4'hF, 4'h0, 1, 8'd0);
      // Reset lands between a rise and its strobe.
      v(1, 4'h0, M_RISE, 0, 4'hF, 4'h0, 1, 8'd0);
      v(1, 4'h0, M_RISE, 0, 4'h0, 4'h0, 1, 8'd0);
      v(1, 4'h0, M_RISE, 0, 4'h0, 4'h0, 1, 8'd0);
      v(1, 4'h0, M_RISE, 0, 4'h0, 4'h0, 1, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h0, 4'h0, 1, 8'd0);
      v(0, 4'h1, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h0, 4'h0, 0, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h1, 4'h0, 0, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h1, 4'h0, 1, 8'd0);
      v(1, 4'h1, M_RISE, 0, 4'h1, 4'h0, 1, 8'd0);

      foreach (tbl[i]) begin
         tick(tbl[i].rst_n, tbl[i].slow, tbl[i].mode, tbl[i].clr);
         chk($sformatf("t%0d.lvl", i), 8'(LEVEL), 8'(tbl[i].level));
         chk($sformatf("t%0d.pls", i), 8'(PULSE), 8'(tbl[i].pulse));
         chk($sformatf("t%0d.arm", i), 8'(ARMED), 8'(tbl[i].armed));
         chk($sformatf("t%0d.cnt", i), EVENT_CNT, tbl[i].cnt);
      end

      // Saturation: 300 rising edges on channel 0.
      mtick(0, 4'h0, M_RISE, 0);
      mtick(0, 4'h0, M_RISE, 0);
      for (int i = 0; i < 4; i++) mtick(1, 4'h0, M_RISE, 0);
      for (int i = 0; i < 300; i++) begin
         mtick(1, 4'h1, M_RISE, 0);
         mtick(1, 4'h1, M_RISE, 0);
         mtick(1, 4'h0, M_RISE, 0);
         mtick(1, 4'h0, M_RISE, 0);
      end
      chk("sat.cnt", EVENT_CNT, 8'd255);

      // CLR coincident with a strobe wins over it.
      mtick(1, 4'h1, M_RISE, 0);
      mtick(1, 4'h1, M_RISE, 0);
      mtick(1, 4'h1, M_RISE, 0);
      chk("clr.pls", 8'(PULSE), 8'h01);
      mtick(1, 4'h1, M_RISE, 1);
      chk("clr.cnt0", EVENT_CNT, 8'd0);
      mtick(1, 4'h1, M_RISE, 0);
      chk("clr.cnt1", EVENT_CNT, 8'd0);

      // Random traffic with occasional mode changes, clears and resets.
      rs = 4'h0;
      rm = M_RISE;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) rs = 4'($urandom);
         if ($urandom_range(0, 15) == 0) rm = 8'($urandom);
         mtick(($urandom_range(0, 99) != 0), rs, rm, ($urandom_range(0, 31) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
